// File: rtl/bnn_pkg.sv
// Shared constants and state type for the BNN pixel feeder.
package bnn_pkg;
  localparam int IMG_W      = 28;
  localparam int PIXEL_NUM  = IMG_W * IMG_W;
  localparam int PIX_IDX_W  = $clog2(PIXEL_NUM);
  localparam int GAP_CYCLES = 1;

  typedef enum logic [1:0] {FILL, READY, GAP, SEND} feeder_state_e;
endpackage

// File: rtl/bnn_frame_buf.sv
// One binarized frame: PIXEL_NUM x 1 storage, one write port, registered read port.
module bnn_frame_buf
  import bnn_pkg::*;
#(
  parameter int DEPTH = PIXEL_NUM,
  parameter int AW    = PIX_IDX_W
) (
  input  logic          clk,
  input  logic          xrst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data
);
  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // rd_data only moves on a read, so it doubles as the held pixel output.
  always_ff @(posedge clk) begin
    if (!xrst)      rd_data <= 1'b0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/bnn_pixel_feeder.sv
// Binarizes a grayscale pixel stream into a frame buffer and replays it bit-serially to the BNN.
// Define BNN_FEEDER_PINGPONG_EN for two buffers so the next frame fills while one is sent.
module bnn_pixel_feeder
  import bnn_pkg::*;
#(
  parameter int THRESH = 128,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             xrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             rcv_req,
  output logic             rcv_ack,
  output logic             inputs,
  output logic             busy,
  output logic [CNT_W-1:0] frames_sent
);
  // state | meaning
  // FILL  | send-side buffer not yet full
  // READY | frame held, waiting for rcv_req
  // GAP   | idle before SEND; read of pixel 0 issued in its last cycle
  // SEND  | rcv_ack high, one pixel per cycle

  localparam int AW = PIX_IDX_W;
  localparam logic [AW-1:0] LAST = AW'(PIXEL_NUM - 1);
`ifdef BNN_FEEDER_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  feeder_state_e state;
  logic [AW-1:0] wr_idx, rd_idx, rd_addr;
  logic [1:0]    full, full_nxt, rd_bits, gap_cnt;
  logic          wr_sel, wr_sel_nxt, rd_sel, rd_sel_nxt, out_sel;
  logic          accept, pix_bit, fill_done, send_done, rd_en;

  assign accept    = in_valid && in_ready;
  assign pix_bit   = (int'(in_data) >= THRESH);
  assign fill_done = accept && (wr_idx == LAST);
  assign send_done = (state == SEND) && (rd_idx == LAST);
  assign rd_en     = ((state == GAP) && (gap_cnt == '0)) ||
                     ((state == SEND) && (rd_idx != LAST));
  assign rd_addr   = (state == SEND) ? rd_idx + AW'(1) : '0;
  assign inputs    = rd_bits[out_sel];

  // Buffer bookkeeping; with one buffer the selects never toggle.
  always_comb begin
    full_nxt   = full;
    wr_sel_nxt = wr_sel;
    rd_sel_nxt = rd_sel;
    if (send_done) begin
      full_nxt[rd_sel] = 1'b0;
      rd_sel_nxt       = rd_sel ^ PP;
    end
    if (fill_done) begin
      full_nxt[wr_sel] = 1'b1;
      wr_sel_nxt       = wr_sel ^ PP;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_buf
    if (b == 0 || PP == 1'b1) begin : g_inst
      bnn_frame_buf #(.DEPTH(PIXEL_NUM), .AW(AW)) u_buf (
        .clk     (clk),
        .xrst    (xrst),
        .wr_en   (accept && (wr_sel == 1'(b))),
        .wr_addr (wr_idx),
        .wr_data (pix_bit),
        .rd_en   (rd_en && (rd_sel == 1'(b))),
        .rd_addr (rd_addr),
        .rd_data (rd_bits[b])
      );
    end else begin : g_none
      assign rd_bits[b] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      state       <= FILL;
      wr_idx      <= '0;
      rd_idx      <= '0;
      full        <= '0;
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b0;
      out_sel     <= 1'b0;
      gap_cnt     <= '0;
      in_ready    <= 1'b0;
      rcv_ack     <= 1'b0;
      busy        <= 1'b0;
      frames_sent <= '0;
    end else begin
      full     <= full_nxt;
      wr_sel   <= wr_sel_nxt;
      rd_sel   <= rd_sel_nxt;
      in_ready <= !full_nxt[wr_sel_nxt];
      busy     <= |full_nxt;
      if (accept) wr_idx <= fill_done ? '0 : wr_idx + AW'(1);

      case (state)
        FILL: begin
          if (full_nxt[rd_sel_nxt]) state <= READY;
        end
        READY: begin
          if (rcv_req) begin
            state   <= GAP;
            gap_cnt <= 2'(GAP_CYCLES - 1);
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state   <= SEND;
            rcv_ack <= 1'b1;
            out_sel <= rd_sel;
          end else begin
            gap_cnt <= gap_cnt - 2'd1;
          end
        end
        SEND: begin
          if (send_done) begin
            rd_idx      <= '0;
            rcv_ack     <= 1'b0;
            frames_sent <= frames_sent + CNT_W'(1);
            state       <= full_nxt[rd_sel_nxt] ? READY : FILL;
          end else begin
            rd_idx <= rd_idx + AW'(1);
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_bnn_pixel_feeder.sv
// Self-checking bench for bnn_pixel_feeder; honours BNN_FEEDER_PINGPONG_EN when defined.
module tb_bnn_pixel_feeder;
  localparam int PIX = 784;
  localparam int CW  = 2;
`ifdef BNN_FEEDER_PINGPONG_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  logic          clk = 1'b0, xrst = 1'b0, in_valid = 1'b0, rcv_req = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready, rcv_ack, inputs, busy;
  logic [CW-1:0] frames_sent;

  int n_checks = 0, n_fail = 0;
  // Reference model: complete frames held (incl. one being sent), pixels of the
  // frame in progress, expected bit stream in arrival order, expected frame count.
  int pend = 0, fill_cnt = 0, exp_fs = 0;
  bit exp_q[$];
  logic cap[PIX];

  typedef struct { logic [7:0] data; logic bit_exp; } vec_t;
  vec_t tbl[8];
  int fs_seq[5];

  bnn_pixel_feeder #(.THRESH(128), .CNT_W(CW)) dut (
    .clk         (clk),
    .xrst        (xrst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .rcv_req     (rcv_req),
    .rcv_ack     (rcv_ack),
    .inputs      (inputs),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_pix(input logic [7:0] d);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 4000) begin
      step();
      guard++;
    end
    check("in_ready_wait", guard < 4000, 1);
    if (guard < 4000) begin
      step();
      exp_q.push_back(d >= 8'd128);
      fill_cnt++;
      if (fill_cnt == PIX) begin
        fill_cnt = 0;
        pend++;
      end
    end
    in_valid = 1'b0;
  endtask

  // mode 0: alternating 127/128, mode 1: threshold table, mode 2: random
  task automatic fill_frame(input int mode, input bit bursty);
    logic [7:0] d;
    for (int i = 0; i < PIX; i++) begin
      case (mode)
        0:       d = (i % 2 == 1) ? 8'd128 : 8'd127;
        1:       d = tbl[i % 8].data;
        default: d = 8'($urandom_range(0, 255));
      endcase
      push_pix(d);
      if (bursty && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
    end
    check("busy_full", busy, 1);
    check("in_ready_full", in_ready, pend < NBUF);
  endtask

  task automatic receive(input int drop_at, input int rst_at);
    int rise = -1, last = -1, n_ack = 0, mism = 0;
    bit done = 0;
    rcv_req = 1'b1;
    for (int s = 1; s <= 2000 && !done; s++) begin
      step();
      if (rcv_ack) begin
        if (rise < 0) rise = s;
        if (n_ack < PIX) cap[n_ack] = inputs;
        n_ack++;
        last = s;
        if (n_ack == drop_at) rcv_req = 1'b0;
        if (n_ack == 300) begin
          check("in_ready_send", in_ready, pend < NBUF);
          check("busy_send", busy, 1);
        end
        if (n_ack == rst_at) begin
          xrst = 1'b0;
          rcv_req = 1'b0;
          step();
          pend = 0; fill_cnt = 0; exp_fs = 0;
          exp_q.delete();
          check("rst_rcv_ack", rcv_ack, 0);
          check("rst_frames_sent", frames_sent, 0);
          check("rst_busy", busy, 0);
          check("rst_in_ready", in_ready, 0);
          xrst = 1'b1;
          step();
          check("rst_release_in_ready", in_ready, 1);
          return;
        end
      end else if (rise >= 0) begin
        done = 1;
      end
    end
    rcv_req = 1'b0;
    check("recv_done", done, 1);
    check("ack_rise_cycle", rise, 2);
    check("ack_count", n_ack, PIX);
    check("ack_last_cycle", last, PIX + 1);
    if (pend > 0) pend--;
    exp_fs = (exp_fs + 1) % (1 << CW);
    check("frames_sent", frames_sent, exp_fs);
    check("busy_after_send", busy, pend > 0);
    check("in_ready_after_send", in_ready, pend < NBUF);
    for (int k = 0; k < PIX; k++)
      if (k >= exp_q.size() || cap[k] !== exp_q[k]) mism++;
    check("frame_bits_mismatches", mism, 0);
    for (int k = 0; k < PIX && exp_q.size() > 0; k++) void'(exp_q.pop_front());
  endtask

  initial begin
    int bad;
    tbl[0] = '{8'd0,   1'b0};
    tbl[1] = '{8'd127, 1'b0};
    tbl[2] = '{8'd128, 1'b1};
    tbl[3] = '{8'd129, 1'b1};
    tbl[4] = '{8'd255, 1'b1};
    tbl[5] = '{8'd1,   1'b0};
    tbl[6] = '{8'd126, 1'b0};
    tbl[7] = '{8'd200, 1'b1};
    fs_seq = '{1, 2, 3, 0, 1};

    // Reset with inputs active
    xrst = 1'b0; in_valid = 1'b1; rcv_req = 1'b1; in_data = 8'd255;
    repeat (3) begin
      step();
      check("reset_in_ready", in_ready, 0);
      check("reset_rcv_ack", rcv_ack, 0);
      check("reset_frames_sent", frames_sent, 0);
      check("reset_busy", busy, 0);
    end
    check("reset_inputs", inputs, 0);
    xrst = 1'b1; in_valid = 1'b0; rcv_req = 1'b0;
    step();
    check("release_in_ready", in_ready, 1);

    // Threshold boundary: alternating 127/128
    fill_frame(0, 0);
    receive(0, 0);
    bad = 0;
    for (int k = 0; k < PIX; k++) if (cap[k] !== 1'(k % 2)) bad++;
    check("alt_pattern_bits", bad, 0);

    // Table frame, then hold rcv_req low for 50 cycles with a waiting source
    fill_frame(1, 1);
    rcv_req = 1'b0;
    in_valid = (NBUF == 1);
    in_data = 8'd200;
    bad = 0;
    repeat (50) begin
      step();
      if (rcv_ack !== 1'b0 || in_ready !== 1'(pend < NBUF) || busy !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    check("hold_quiet_violations", bad, 0);
    receive(0, 0);
    for (int r = 0; r < 8; r++) check($sformatf("tbl_bit%0d", r), cap[r], tbl[r].bit_exp);

    // rcv_req dropped at pixel 100
    fill_frame(2, 1);
    receive(100, 0);

    // Reset in the middle of SEND
    fill_frame(2, 0);
    receive(0, 400);
    rcv_req = 1'b1;
    bad = 0;
    repeat (20) begin
      step();
      if (rcv_ack !== 1'b0 || busy !== 1'b0) bad++;
    end
    rcv_req = 1'b0;
    check("no_ack_without_frame", bad, 0);

    // Bursty random frames through the counter wrap
    for (int f = 0; f < 5; f++) begin
      fill_frame(2, 1);
      receive(0, 0);
      check($sformatf("wrap_seq%0d", f), frames_sent, fs_seq[f]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
